// File: rtl/nonrestoring_divider_if.sv
// Request/response bundle for nonrestoring_divider.
//   master : drives start, is_signed, dividend, divisor; observes results.
//   slave  : the divider itself.
// Signals:
//   start       request pulse, sampled only while the divider is idle
//   is_signed   1 = two's-complement operands, 0 = unsigned
//   dividend    numerator N
//   divisor     denominator D
//   busy        high while an operation is in flight
//   done        one-cycle pulse, results valid
//   quotient    Q, held until the next accepted start
//   remainder   R, held like quotient
//   div_by_zero set together with done when D = 0
interface nonrestoring_divider_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/nonrestoring_divider.sv
// 32-bit signed/unsigned iterative divider, one non-restoring step per cycle.
// Operands are reduced to magnitudes on start, 32 iterations run in RUN,
// FIX corrects the remainder and applies result signs, DONE pulses done.
// Start-to-done latency is 34 cycles; a zero divisor finishes in 1 cycle.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  nonrestoring_divider_if.slave (see the interface file)
module nonrestoring_divider (
  input  logic                         clk,
  input  logic                         rst,
  nonrestoring_divider_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] p_q, p_d;        // signed partial remainder
  logic [31:0] qr_q, qr_d;      // quotient shift register (starts as |N|)
  logic [31:0] dmag_q, dmag_d;  // |D|
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  // Magnitudes of the incoming operands. The 32-bit two's-complement
  // negation read as unsigned equals the exact 33-bit magnitude, so
  // -2^31 yields 0x80000000 correctly.
  logic        n_neg, d_neg;
  logic [31:0] n_mag, d_mag;

  // One non-restoring step, widened by one bit so that 2*P stays exact even
  // when |D| is close to 2^32; the result always fits back into 33 bits.
  logic [33:0] step_in, step_sum;
  logic [31:0] rem_mag;

  always_comb begin
    n_neg = bus.is_signed & bus.dividend[31];
    d_neg = bus.is_signed & bus.divisor[31];
    n_mag = n_neg ? (~bus.dividend + 32'd1) : bus.dividend;
    d_mag = d_neg ? (~bus.divisor + 32'd1) : bus.divisor;

    step_in  = {p_q[32], p_q, qr_q[31]};
    step_sum = p_q[32] ? (step_in + {2'b00, dmag_q})
                       : (step_in - {2'b00, dmag_q});

    // True remainder lies in [0, |D|), so modulo-2^32 addition is exact.
    rem_mag = p_q[32] ? (p_q[31:0] + dmag_q) : p_q[31:0];
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    qr_d    = qr_q;
    dmag_d  = dmag_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dbz_d   = 1'b0;
          q_neg_d = n_neg ^ d_neg;
          r_neg_d = n_neg;
          dmag_d  = d_mag;
          qr_d    = n_mag;
          p_d     = '0;
          cnt_d   = '0;
          if (bus.divisor == 32'd0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = step_sum[32:0];
        // The top bit equals bit 32 of the new P, since P fits in 33 bits.
        qr_d  = {qr_q[30:0], ~step_sum[33]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        quot_d  = q_neg_q ? (~qr_q + 32'd1) : qr_q;
        rem_d   = r_neg_q ? (~rem_mag + 32'd1) : rem_mag;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the result registers, is reset so that an
  // aborted operation leaves every output at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      qr_q    <= '0;
      dmag_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      qr_q    <= qr_d;
      dmag_q  <= dmag_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed corner cases,
// start-while-busy, reset abort, then random operands against a reference
// built from plain 64-bit integer division.
module tb_nonrestoring_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nonrestoring_divider_if bus ();

  nonrestoring_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division as defined for integers; D = 0 special.
  function automatic void ref_div(input logic sgn, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint a, b;
    if (d == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = n;
      dz = 1'b1;
      return;
    end
    dz = 1'b0;
    if (sgn) begin
      a = longint'($signed(n));
      b = longint'($signed(d));
    end else begin
      a = longint'({32'd0, n});
      b = longint'({32'd0, d});
    end
    q = 32'(a / b);
    r = 32'(a % b);
  endfunction

  // Issue one operation and check latency, busy, results and done width.
  // Operand inputs are scrambled every busy cycle; with inject set, extra
  // start pulses are sent at cycles 5 and 20 and in the DONE cycle.
  task automatic run_op(input logic sgn, input logic [31:0] n, input logic [31:0] d,
                        input bit inject, input string tag);
    logic [31:0] eq, er;
    logic        edz;
    int          cyc;
    int          exp_lat;
    bit          busy_ok;
    ref_div(sgn, n, d, eq, er, edz);
    exp_lat = (d == 32'd0) ? 1 : 34;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = n;
    bus.divisor   = d;
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 1;
    busy_ok   = 1'b1;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      bus.start     = inject && (cyc == 5 || cyc == 20);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(edz));
    if (inject) begin
      bus.start    = 1'b1;
      bus.dividend = 32'd77;
      bus.divisor  = 32'd0;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, " start_in_done_busy"}, 32'(bus.busy), 32'd0);
      check({tag, " start_in_done_done"}, 32'(bus.done), 32'd0);
      check({tag, " held_quotient"}, bus.quotient, eq);
    end else begin
      @(negedge clk);
      check({tag, " done_single_pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    bit          saw_done;
    logic        sgn;
    logic [31:0] n, d;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset dbz", 32'(bus.div_by_zero), 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 1'b0, "u_100_7");
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, "s_-100_7");
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0, "s_100_-7");
    run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, "div_zero");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_overflow");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_max");
    run_op(1'b1, 32'h8000_0000, 32'd3, 1'b0, "s_min_3");
    run_op(1'b0, 32'd1000, 32'd3, 1'b1, "start_ignored");

    // Abort a running operation with reset at cycle 15.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd123456;
    bus.divisor   = 32'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort dbz", 32'(bus.div_by_zero), 32'd0);
    check("abort quotient", bus.quotient, 32'd0);
    check("abort remainder", bus.remainder, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    run_op(1'b0, 32'd9, 32'd3, 1'b0, "post_reset_9_3");

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      n   = $urandom;
      d   = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) d = 32'd0;
      run_op(sgn, n, d, 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
